// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: word alignment from control-token runs, then 8b/10b data/control recovery.
// Optional error counter for isolated control tokens is enabled by defining TMDS_ERRCNT_EN.
module tmds_decoder #(
    parameter int CTRL_RUN    = 8,
    parameter int SEARCH_WAIT = 2048,
    parameter int LOSS_WAIT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  din,
    output logic [7:0]  vd,
    output logic [1:0]  cd,
    output logic        vde,
    output logic        locked,
    output logic [3:0]  offset
`ifdef TMDS_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int MAX_AB = (SEARCH_WAIT > LOSS_WAIT) ? SEARCH_WAIT : LOSS_WAIT;
    localparam int MAX_P  = (CTRL_RUN > MAX_AB) ? CTRL_RUN : MAX_AB;
    localparam int CW     = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic {
        S_SEARCH = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [9:0]      prev_q;
    logic [9:0]      sym_q, sym_d;
    logic [CW-1:0]   run_q, run_d;
    logic [CW-1:0]   wait_q, wait_d;
    logic [3:0]      offset_q, offset_d;
    logic            slip_q, slip_d;
    logic [7:0]      vd_q, vd_d;
    logic [1:0]      cd_q, cd_d;
    logic            vde_q, vde_d;

    logic [18:0]     cat;
    logic [9:0]      win [10];
    logic            is_ctrl;
    logic [1:0]      ctrl_code;
    logic [7:0]      dword;
    logic [7:0]      vd_dec;
    logic [CW-1:0]   run_inc;
    logic [CW-1:0]   wait_inc;
    logic [3:0]      offset_nxt;

    // Bit 19 of the full 20-bit concatenation can never fall inside a window.
    assign cat = {din[8:0], prev_q};

    for (genvar gi = 0; gi < 10; gi++) begin : g_win
        assign win[gi] = cat[gi+9:gi];
    end

    always_comb begin
        sym_d = win[0];
        for (int i = 1; i < 10; i++) begin
            if (offset_q == 4'(i)) begin
                sym_d = win[i];
            end
        end
    end

    always_comb begin
        is_ctrl   = 1'b1;
        ctrl_code = 2'b00;
        case (sym_q)
            10'b1101010100: ctrl_code = 2'b00;
            10'b0010101011: ctrl_code = 2'b01;
            10'b0101010100: ctrl_code = 2'b10;
            10'b1010101011: ctrl_code = 2'b11;
            default:        is_ctrl   = 1'b0;
        endcase
    end

    assign dword     = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    assign vd_dec[0] = dword[0];
    for (genvar gi = 1; gi < 8; gi++) begin : g_dec
        assign vd_dec[gi] = sym_q[8] ? (dword[gi] ^ dword[gi-1]) : ~(dword[gi] ^ dword[gi-1]);
    end

    assign run_inc    = (run_q >= CW'(CTRL_RUN)) ? run_q : run_q + CW'(1);
    assign wait_inc   = (&wait_q) ? wait_q : wait_q + CW'(1);
    assign offset_nxt = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        wait_d   = wait_q;
        offset_d = offset_q;
        slip_d   = 1'b0;
        case (state_q)
            S_SEARCH: begin
                // The word sampled on the slip edge used the old offset; skip it.
                if (slip_q) begin
                    run_d = '0;
                end else if (is_ctrl) begin
                    run_d  = run_inc;
                    wait_d = '0;
                    if (run_inc >= CW'(CTRL_RUN)) begin
                        state_d = S_LOCKED;
                        run_d   = '0;
                    end
                end else begin
                    run_d  = '0;
                    wait_d = wait_inc;
                    if (wait_inc >= CW'(SEARCH_WAIT - 1)) begin
                        offset_d = offset_nxt;
                        wait_d   = '0;
                        slip_d   = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (is_ctrl) begin
                    wait_d = '0;
                end else begin
                    wait_d = wait_inc;
                    if (wait_inc >= CW'(LOSS_WAIT - 1)) begin
                        state_d  = S_SEARCH;
                        offset_d = offset_nxt;
                        wait_d   = '0;
                        run_d    = '0;
                        slip_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_SEARCH;
        endcase
    end

    always_comb begin
        vd_d  = vd_q;
        cd_d  = cd_q;
        vde_d = vde_q;
        if (state_q == S_LOCKED) begin
            if (is_ctrl) begin
                vde_d = 1'b0;
                cd_d  = ctrl_code;
            end else begin
                vde_d = 1'b1;
                vd_d  = vd_dec;
            end
        end else begin
            vde_d = 1'b0;
            cd_d  = 2'b00;
            vd_d  = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= '0;
            sym_q    <= '0;
            state_q  <= S_SEARCH;
            run_q    <= '0;
            wait_q   <= '0;
            offset_q <= '0;
            slip_q   <= 1'b0;
            vd_q     <= '0;
            cd_q     <= '0;
            vde_q    <= 1'b0;
        end else begin
            prev_q   <= din;
            sym_q    <= sym_d;
            state_q  <= state_d;
            run_q    <= run_d;
            wait_q   <= wait_d;
            offset_q <= offset_d;
            slip_q   <= slip_d;
            vd_q     <= vd_d;
            cd_q     <= cd_d;
            vde_q    <= vde_d;
        end
    end

    assign vd     = vd_q;
    assign cd     = cd_q;
    assign vde    = vde_q;
    assign locked = (state_q == S_LOCKED);
    assign offset = offset_q;

`ifdef TMDS_ERRCNT_EN
    logic [1:0]  hist_q;
    logic [15:0] err_q, err_d;
    logic        iso_tok;

    // hist_q[0] is the previous symbol's class, hist_q[1] the one before it.
    assign iso_tok = (state_q == S_LOCKED) && !is_ctrl && hist_q[0] && !hist_q[1];
    assign err_d   = (iso_tok && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= 2'b00;
            err_q  <= '0;
        end else begin
            hist_q <= {hist_q[0], is_ctrl};
            err_q  <= err_d;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: stimulus pushes expected pixels, a negedge monitor pops them on vde.
// Builds with or without TMDS_ERRCNT_EN; the error-counter checks are only present when it is defined.
module tb_tmds_decoder;

    typedef struct packed {
        logic [7:0] vd;
        logic [1:0] cd;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] din = 10'd0;

    logic [7:0] vd_o, l_vd;
    logic [1:0] cd_o, l_cd;
    logic       vde_o, l_vde;
    logic       locked_o, l_locked;
    logic [3:0] off_o, l_off;
`ifdef TMDS_ERRCNT_EN
    logic [15:0] err_o, l_err;
`endif

    int   checks = 0;
    int   errors = 0;
    int   enc_cnt = 0;
    logic track = 1'b0;
    logic [1:0] cur_cd = 2'b00;
    exp_t sb_q[$];
    exp_t mon_e;
    int   off_log[$];

    always #5 clk = ~clk;

    tmds_decoder #(.CTRL_RUN(8), .SEARCH_WAIT(16), .LOSS_WAIT(4096)) dut (
        .clk(clk), .rst_n(rst_n), .din(din),
        .vd(vd_o), .cd(cd_o), .vde(vde_o), .locked(locked_o), .offset(off_o)
`ifdef TMDS_ERRCNT_EN
        , .err_cnt(err_o)
`endif
    );

    tmds_decoder #(.CTRL_RUN(8), .SEARCH_WAIT(16), .LOSS_WAIT(64)) dut_l (
        .clk(clk), .rst_n(rst_n), .din(din),
        .vd(l_vd), .cd(l_cd), .vde(l_vde), .locked(l_locked), .offset(l_off)
`ifdef TMDS_ERRCNT_EN
        , .err_cnt(l_err)
`endif
    );

    function automatic logic [9:0] tok(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

    // Transmit-side TMDS video encoder with running disparity in enc_cnt.
    function automatic logic [9:0] enc_data(input logic [7:0] d);
        logic [8:0] qm;
        logic [9:0] q;
        int n1, n1q, n0q;
        n1 = $countones(d);
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            enc_cnt = qm[8] ? enc_cnt + n1q - n0q : enc_cnt + n0q - n1q;
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            q = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            q = {1'b0, qm[8], qm[7:0]};
            enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
        end
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic send_token(input logic [1:0] c);
        din = tok(c);
        cur_cd = c;
        enc_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_data(input logic [7:0] p);
        exp_t e;
        din = enc_data(p);
        if (track) begin
            e.vd = p;
            e.cd = cur_cd;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic acquire(input string tag);
        for (int i = 1; i <= 20; i++) begin
            send_token(2'b00);
            if (i == 9) begin
                chk({tag, "_locked_tok7"}, 32'(locked_o), 32'd0);
                chk({tag, "_l_locked_tok7"}, 32'(l_locked), 32'd0);
            end
            if (i == 10) begin
                chk({tag, "_locked_tok8"}, 32'(locked_o), 32'd1);
                chk({tag, "_l_locked_tok8"}, 32'(l_locked), 32'd1);
            end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented data pixel must match the oldest expected entry.
    always @(negedge clk) begin
        if (vde_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got vd=%0h cd=%0h expected no pixel", vd_o, cd_o);
            end else begin
                mon_e = sb_q.pop_front();
                if (vd_o !== mon_e.vd || cd_o !== mon_e.cd) begin
                    errors++;
                    $display("FAIL sb_pixel: got vd=%0h cd=%0h expected vd=%0h cd=%0h",
                             vd_o, cd_o, mon_e.vd, mon_e.cd);
                end else begin
                    $display("ok   sb_pixel: vd=%0h cd=%0h", vd_o, cd_o);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] s, prev_s;
        logic [3:0] last_off;

        rst_n = 1'b0;
        din = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vd", 32'(vd_o), 32'd0);
        chk("rst_cd", 32'(cd_o), 32'd0);
        chk("rst_vde", 32'(vde_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_offset", 32'(off_o), 32'd0);
        rst_n = 1'b1;

        // Aligned token run then one pixel.
        acquire("aligned");
        track = 1'b1;
        send_data(8'hA5);
        send_token(2'b00);
        chk("a5_vde_early", 32'(vde_o), 32'd0);
        send_token(2'b00);
        chk("a5_vde", 32'(vde_o), 32'd1);
        chk("a5_vd", 32'(vd_o), 32'hA5);
        chk("a5_cd", 32'(cd_o), 32'd0);
        send_token(2'b00);
        chk("a5_vde_after", 32'(vde_o), 32'd0);
        send_token(2'b00);

        // Round trip: full pixel ramp, then blanking with each control code.
        for (int p = 0; p < 256; p++) send_data(8'(p));
        for (int c = 0; c < 4; c++) begin
            repeat (4) send_token(2'(c));
            send_data(8'(8'h0F + 16 * c));
        end
        repeat (4) send_token(2'b11);
        chk("rt_locked", 32'(locked_o), 32'd1);
        chk("rt_cd_hold", 32'(cd_o), 32'd3);

`ifdef TMDS_ERRCNT_EN
        chk("err_init", 32'(err_o), 32'd0);
        send_data(8'h5A);
        send_token(2'b10);
        send_data(8'hC3);
        repeat (3) send_token(2'b00);
        chk("err_isolated", 32'(err_o), 32'd1);
        send_data(8'h77);
        send_token(2'b10);
        send_token(2'b10);
        send_data(8'h88);
        repeat (3) send_token(2'b00);
        chk("err_run2", 32'(err_o), 32'd1);
`endif

        // Reset in the middle of a data burst.
        send_data(8'h11);
        send_data(8'h22);
        chk("mid_locked_before", 32'(locked_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_locked", 32'(locked_o), 32'd0);
        chk("mid_vde", 32'(vde_o), 32'd0);
        chk("mid_vd", 32'(vd_o), 32'd0);
        chk("mid_cd", 32'(cd_o), 32'd0);
        chk("mid_offset", 32'(off_o), 32'd0);
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        acquire("reacq");

        // Lock loss on the short-timeout instance.
        pulse_reset();
        acquire("loss");
        for (int j = 1; j <= 64; j++) begin
            send_data(8'(j * 5));
            if (j == 64) chk("loss_still_locked", 32'(l_locked), 32'd1);
        end
        send_token(2'b00);
        chk("loss_locked", 32'(l_locked), 32'd0);
        chk("loss_offset", 32'(l_off), 32'd1);
        chk("loss_main_locked", 32'(locked_o), 32'd1);
        chk("loss_main_offset", 32'(off_o), 32'd0);
        repeat (3) send_token(2'b00);

        // Stream rotated by 3 bits: two blanking lines of 160 tokens and 640 pixels.
        pulse_reset();
        off_log.delete();
        last_off = 4'd0;
        cur_cd = 2'b00;
        prev_s = tok(2'b00);
        for (int line = 0; line < 2; line++) begin
            for (int w = 0; w < 808; w++) begin
                if (w < 160 || w >= 800) begin
                    s = tok(2'b00);
                    enc_cnt = 0;
                end else begin
                    s = enc_data(8'(line * 37 + w * 3));
                    if (line < 2) begin
                        sb_q.push_back('{vd: 8'(line * 37 + w * 3), cd: 2'b00});
                    end
                end
                if (line == 0 || w < 800) begin
                    din = {s[6:0], prev_s[9:7]};
                    prev_s = s;
                    @(posedge clk);
                    #1;
                    if (off_o != last_off) begin
                        off_log.push_back(int'(off_o));
                        last_off = off_o;
                    end
                end
            end
        end
        for (int w = 0; w < 8; w++) begin
            s = tok(2'b00);
            din = {s[6:0], prev_s[9:7]};
            prev_s = s;
            @(posedge clk);
            #1;
        end
        chk("mis_offset_steps", 32'(off_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < off_log.size()) chk("mis_offset_step", 32'(off_log[i]), 32'(i + 1));
        end
        chk("mis_offset", 32'(off_o), 32'd3);
        chk("mis_locked", 32'(locked_o), 32'd1);

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
